// File: rtl/ysyx_25020037_stage_seq_pkg.sv
// Shared definitions for the multicycle stage sequencer: state codes,
// default parameters and a small state-classification helper.
package ysyx_25020037_stage_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_LS   = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6,
        ST_ERR  = 3'd7
    } stage_e;

    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_CNT_W       = 64;
    // Wide enough for the largest legal TIMEOUT_CYC (65535).
    localparam int WAIT_W          = 16;

    function automatic logic is_wait_state(input stage_e s);
        return (s == ST_IF) || (s == ST_ID) || (s == ST_EX) ||
               (s == ST_LS) || (s == ST_WB);
    endfunction

endpackage

// File: rtl/ysyx_25020037_perf_cnt.sv
// Cycle and retired-instruction counters with a freeze control; intended to
// back mcycle/minstret later. Both counters wrap silently.
module ysyx_25020037_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_inc,
    input  logic             instret_inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instret_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else if (!freeze) begin
            if (cycle_inc) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            if (instret_inc) begin
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: rtl/ysyx_25020037_stage_seq.sv
// Multicycle instruction sequencer: launches IF/ID/EX/LS/WB in order, waits for
// each done pulse, skips LS for non-memory ops, halts on ebreak, times out hung stages.
module ysyx_25020037_stage_seq
    import ysyx_25020037_stage_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    output logic             if_go,
    input  logic             if_done,
    output logic             id_go,
    input  logic             id_done,
    input  logic             id_need_mem,
    input  logic             id_halt,
    output logic             ex_go,
    input  logic             ex_done,
    output logic             ls_go,
    input  logic             ls_done,
    output logic             wb_go,
    input  logic             wb_done,
    output logic             commit,
    output logic             halted,
    output logic             err,
    output logic [2:0]       err_stage,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    stage_e            state_reg;
    stage_e            state_next;
    logic              first_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              need_mem_reg;
    logic              halt_reg;
    logic              halted_reg;
    logic              err_reg;
    logic [2:0]        err_stage_reg;

    logic done_cur;
    logic in_wait;
    logic timeout;
    logic frozen;

    always_comb begin
        done_cur   = 1'b0;
        state_next = state_reg;
        if_go      = 1'b0;
        id_go      = 1'b0;
        ex_go      = 1'b0;
        ls_go      = 1'b0;
        wb_go      = 1'b0;
        commit     = 1'b0;
        in_wait    = is_wait_state(state_reg);

        case (state_reg)
            ST_IDLE: begin
                if (run_en) state_next = ST_IF;
            end
            ST_IF: begin
                if_go    = first_reg;
                done_cur = if_done;
                if (if_done) state_next = ST_ID;
            end
            ST_ID: begin
                id_go    = first_reg;
                done_cur = id_done;
                if (id_done) state_next = ST_EX;
            end
            ST_EX: begin
                ex_go    = first_reg;
                done_cur = ex_done;
                if (ex_done) state_next = need_mem_reg ? ST_LS : ST_WB;
            end
            ST_LS: begin
                ls_go    = first_reg;
                done_cur = ls_done;
                if (ls_done) state_next = ST_WB;
            end
            ST_WB: begin
                wb_go    = first_reg;
                done_cur = wb_done;
                commit   = wb_done;
                if (wb_done) begin
                    if (halt_reg)    state_next = ST_HALT;
                    else if (run_en) state_next = ST_IF;
                    else             state_next = ST_IDLE;
                end
            end
            default: ;
        endcase

        // A done arriving in the last allowed cycle beats the timeout.
        timeout = in_wait && !done_cur && (wait_cnt_reg == WAIT_LAST);
        if (timeout) state_next = ST_ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            first_reg     <= 1'b0;
            wait_cnt_reg  <= '0;
            need_mem_reg  <= 1'b0;
            halt_reg      <= 1'b0;
            halted_reg    <= 1'b0;
            err_reg       <= 1'b0;
            err_stage_reg <= 3'd0;
        end else begin
            state_reg <= state_next;
            // Wait states never loop onto themselves, so a change of state is an entry.
            first_reg <= (state_next != state_reg) && is_wait_state(state_next);
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (in_wait) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
            if (state_reg == ST_ID && id_done) begin
                need_mem_reg <= id_need_mem;
                halt_reg     <= id_halt;
            end
            if (state_next == ST_HALT) begin
                halted_reg <= 1'b1;
            end
            if (timeout) begin
                err_reg       <= 1'b1;
                err_stage_reg <= state_reg;
            end
        end
    end

    assign frozen = (state_reg == ST_HALT) || (state_reg == ST_ERR);

    ysyx_25020037_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .cycle_inc   (1'b1),
        .instret_inc (commit),
        .freeze      (frozen),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    assign halted    = halted_reg;
    assign err       = err_reg;
    assign err_stage = err_stage_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_ysyx_25020037_stage_seq.sv
// Directed + randomized bench for the stage sequencer; unit latencies and
// off-state done noise come from $urandom and are checked against a cycle model.
module tb_ysyx_25020037_stage_seq;

    localparam int TO    = 8;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             run_en;
    logic             if_go, id_go, ex_go, ls_go, wb_go;
    logic             if_done, id_done, id_need_mem, id_halt, ex_done, ls_done, wb_done;
    logic             commit, halted, err;
    logic [2:0]       err_stage, state_o;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_cyc;
    logic [63:0] exp_ret;
    bit          frozen;

    ysyx_25020037_stage_seq #(
        .TIMEOUT_CYC(TO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .if_go      (if_go),
        .if_done    (if_done),
        .id_go      (id_go),
        .id_done    (id_done),
        .id_need_mem(id_need_mem),
        .id_halt    (id_halt),
        .ex_go      (ex_go),
        .ex_done    (ex_done),
        .ls_go      (ls_go),
        .ls_done    (ls_done),
        .wb_go      (wb_go),
        .wb_done    (wb_done),
        .commit     (commit),
        .halted     (halted),
        .err        (err),
        .err_stage  (err_stage),
        .state_o    (state_o),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_go(input int code);
        logic [4:0] v;
        v = 5'b10000;
        if (code >= 1 && code <= 5) return v >> (code - 1);
        return 5'd0;
    endfunction

    // One clock: the model counts the cycle unless the sequencer is parked.
    task automatic step();
        if (!frozen) exp_cyc++;
        @(posedge clk);
        #1;
    endtask

    // Drive the done for stage `code` (fire) and random noise on all others.
    task automatic drive(input int code, input bit fire, input bit mem, input bit hlt);
        logic [4:0] r;
        r           = 5'($urandom);
        if_done     = (code == 1) ? fire : r[4];
        id_done     = (code == 2) ? fire : r[3];
        ex_done     = (code == 3) ? fire : r[2];
        ls_done     = (code == 4) ? fire : r[1];
        wb_done     = (code == 5) ? fire : r[0];
        id_need_mem = (code == 2 && fire) ? mem : 1'($urandom);
        id_halt     = (code == 2 && fire) ? hlt : 1'($urandom);
    endtask

    task automatic clear_inputs();
        if_done = 0; id_done = 0; ex_done = 0; ls_done = 0; wb_done = 0;
        id_need_mem = 0; id_halt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},   64'(state_o), 64'd0);
        check({tag, "_go"},      64'({if_go, id_go, ex_go, ls_go, wb_go}), 64'd0);
        check({tag, "_commit"},  64'(commit), 64'd0);
        check({tag, "_halted"},  64'(halted), 64'd0);
        check({tag, "_err"},     64'(err), 64'd0);
        check({tag, "_errstg"},  64'(err_stage), 64'd0);
        check({tag, "_cycle"},   cycle_cnt, 64'd0);
        check({tag, "_instret"}, instret_cnt, 64'd0);
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, releases away from an edge.
    task automatic do_reset(input string tag);
        rst    = 1'b1;
        run_en = 1'b0;
        clear_inputs();
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst     = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        frozen  = 0;
        check_reset_vals({tag, "_rel"});
    endtask

    // Stay in stage `code` for delay+1 cycles; done fires in the last one.
    task automatic do_stage(input int code, input int delay, input bit mem, input bit hlt);
        for (int k = 0; k <= delay; k++) begin
            check($sformatf("state_s%0d_k%0d", code, k), 64'(state_o), 64'(code));
            check($sformatf("go_s%0d_k%0d", code, k),
                  64'({if_go, id_go, ex_go, ls_go, wb_go}),
                  64'((k == 0) ? exp_go(code) : 5'd0));
            check($sformatf("cycle_s%0d_k%0d", code, k), cycle_cnt, exp_cyc);
            drive(code, k == delay, mem, hlt);
            #1;
            check($sformatf("commit_s%0d_k%0d", code, k), 64'(commit),
                  64'((code == 5 && k == delay) ? 1 : 0));
            step();
        end
    endtask

    task automatic run_instr(input bit mem, input bit hlt, input bit run_next,
                             input int d_if, input int d_id, input int d_ex,
                             input int d_ls, input int d_wb);
        do_stage(1, d_if, 1'b0, 1'b0);
        do_stage(2, d_id, mem, hlt);
        run_en = run_next;
        do_stage(3, d_ex, 1'b0, 1'b0);
        if (mem) do_stage(4, d_ls, 1'b0, 1'b0);
        do_stage(5, d_wb, 1'b0, 1'b0);
        exp_ret++;
        check("instret", instret_cnt, exp_ret);
        check("cycle_after_wb", cycle_cnt, exp_cyc);
        if (hlt) begin
            frozen = 1;
            check("state_halt", 64'(state_o), 64'd6);
            check("halted", 64'(halted), 64'd1);
        end else begin
            check("state_after_wb", 64'(state_o), run_next ? 64'd1 : 64'd0);
            check("halted_clear", 64'(halted), 64'd0);
        end
        check("err_clear", 64'(err), 64'd0);
    endtask

    task automatic run_rand(input bit hlt);
        run_instr(1'($urandom), hlt, 1'b1,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
    endtask

    initial begin
        rst = 1'b1;
        run_en = 1'b0;
        clear_inputs();
        exp_cyc = 0;
        exp_ret = 0;
        frozen = 0;
        #2;

        // Single-cycle stages straight out of reset.
        do_reset("rst0");
        run_en = 1'b1;
        step();
        check("t1_ifgo_cycle", cycle_cnt, 64'd1);
        run_instr(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        check("t1_instret", instret_cnt, 64'd1);
        check("t1_cycle5", cycle_cnt, 64'd5);

        // Load with LSU answering on the last cycle before timeout.
        run_instr(1'b1, 1'b0, 1'b1, 1, 2, 0, 7, 1);
        // EX done on its 8th cycle: must not time out.
        run_instr(1'b0, 1'b0, 1'b1, 0, 0, 7, 0, 0);
        for (int i = 0; i < 6; i++) run_rand(1'b0);

        // ebreak on the third instruction, then a long parked stretch.
        do_reset("rst1");
        run_en = 1'b1;
        step();
        run_rand(1'b0);
        run_rand(1'b0);
        run_rand(1'b1);
        for (int i = 0; i < 100; i++) begin
            check("halt_state", 64'(state_o), 64'd6);
            check("halt_go", 64'({if_go, id_go, ex_go, ls_go, wb_go}), 64'd0);
            check("halt_cycle", cycle_cnt, exp_cyc);
            drive(0, 1'b0, 1'b0, 1'b0);
            run_en = 1'($urandom);
            #1;
            check("halt_commit", 64'(commit), 64'd0);
            step();
        end
        check("halt_instret", instret_cnt, 64'd3);

        // EX never finishes: ERR after 8 cycles in EX.
        do_reset("rst2");
        run_en = 1'b1;
        step();
        do_stage(1, 0, 1'b0, 1'b0);
        do_stage(2, 1, 1'b0, 1'b0);
        for (int k = 0; k < TO; k++) begin
            check($sformatf("to_state_k%0d", k), 64'(state_o), 64'd3);
            check($sformatf("to_err_k%0d", k), 64'(err), 64'd0);
            drive(3, 1'b0, 1'b0, 1'b0);
            step();
        end
        frozen = 1;
        check("to_state_err", 64'(state_o), 64'd7);
        check("to_err", 64'(err), 64'd1);
        check("to_err_stage", 64'(err_stage), 64'd3);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'b0, 1'b0, 1'b0);
            step();
            check("err_state", 64'(state_o), 64'd7);
            check("err_go", 64'({if_go, id_go, ex_go, ls_go, wb_go}), 64'd0);
            check("err_cycle", cycle_cnt, exp_cyc);
        end

        // run_en dropped during EX: retire, idle, restart on demand.
        do_reset("rst3");
        run_en = 1'b1;
        step();
        run_instr(1'b1, 1'b0, 1'b0, 0, 1, 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            check("idle_state", 64'(state_o), 64'd0);
            check("idle_go", 64'({if_go, id_go, ex_go, ls_go, wb_go}), 64'd0);
            check("idle_cycle", cycle_cnt, exp_cyc);
            drive(0, 1'b0, 1'b0, 1'b0);
            step();
        end
        run_en = 1'b1;
        step();
        run_instr(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
        check("restart_instret", instret_cnt, 64'd2);

        // Reset while waiting on LSU, then a clean restart.
        do_reset("rst4");
        run_en = 1'b1;
        step();
        do_stage(1, 0, 1'b0, 1'b0);
        do_stage(2, 0, 1'b1, 1'b0);
        do_stage(3, 0, 1'b0, 1'b0);
        check("ls_state", 64'(state_o), 64'd4);
        check("ls_go", 64'(ls_go), 64'd1);
        drive(4, 1'b0, 1'b0, 1'b0);
        do_reset("rst_ls");
        run_en = 1'b1;
        step();
        run_rand(1'b0);
        check("post_rst_instret", instret_cnt, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
